// File: rtl/ksa_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
package ksa_pkg;

  localparam int KSA_MAX_WIDTH = 64;

  typedef struct packed {
    logic g;
    logic p;
  } ksa_gp_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Number of prefix pipeline stages; the last stage may carry fewer levels.
  function automatic int ksa_stages(input int width, input int lvl_per_stage);
    return (clog2(width) + lvl_per_stage - 1) / lvl_per_stage;
  endfunction

endpackage

// File: rtl/ksa_pipe_if.sv
// Operand/result handshake bundle for ksa_pipe; ovf exists only with KSA_PIPE_OVF_EN.
interface ksa_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef KSA_PIPE_OVF_EN
   logic             ovf;

   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
`else
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout);
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone prefix level combining each bit with the bit DIST below it.
module ksa_prefix_level
   import ksa_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  ksa_gp_t [WIDTH-1:0] src,
   output ksa_gp_t [WIDTH-1:0] dst
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < DIST) begin : g_pass
         assign dst[i] = src[i];
      end else begin : g_op
         assign dst[i].g = src[i].g | (src[i].p & src[i-DIST].g);
         assign dst[i].p = src[i].p & src[i-DIST].p;
      end
   end

endmodule

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready flow control and a registered result.
// Optional signed-overflow output enabled by defining KSA_PIPE_OVF_EN.
module ksa_pipe
   import ksa_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int LVL_PER_STAGE = 1
) (
   input logic       clk,
   input logic       rst_n,
   ksa_pipe_if.slave bus
);

   localparam int L = clog2(WIDTH);
   localparam int S = ksa_stages(WIDTH, LVL_PER_STAGE);

   logic                adv;
   logic [S:0]          v_q;
   ksa_gp_t [WIDTH-1:0] gp_in;
   ksa_gp_t [WIDTH-1:0] gp_q    [0:S];
   logic    [WIDTH-1:0] p_q     [0:S];
   logic    [S:0]       cin_q;
   ksa_gp_t [WIDTH-1:0] lvl_out [0:L-1];
   logic    [WIDTH-1:0] carry;
   logic    [WIDTH-1:0] final_p;
   logic                unused_p;
   logic                out_valid_q;
   logic    [WIDTH-1:0] sum_q;
   logic                cout_q;

   // Index of the prefix level whose output feeds stage register s.
   function automatic int last_lvl(input int s);
      return ((s * LVL_PER_STAGE < L) ? s * LVL_PER_STAGE : L) - 1;
   endfunction

   // The whole pipe moves as one: it only advances when the output slot is free.
   assign adv          = !out_valid_q || bus.out_ready;
   assign bus.in_ready = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;

   // NOTE: every always_comb output gets a value on every path; missing one infers a latch.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         gp_in[i].g = bus.a[i] & bus.b[i];
         gp_in[i].p = bus.a[i] ^ bus.b[i];
      end
      gp_in[0].g = (bus.a[0] & bus.b[0]) | ((bus.a[0] ^ bus.b[0]) & bus.cin);
   end

   for (genvar k = 0; k < L; k++) begin : g_lvl
      ksa_gp_t [WIDTH-1:0] src;
      if (k % LVL_PER_STAGE == 0) begin : g_head
         assign src = gp_q[k / LVL_PER_STAGE];
      end else begin : g_chain
         assign src = lvl_out[k-1];
      end
      ksa_prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
         .src (src),
         .dst (lvl_out[k])
      );
   end

   // After the final level, G of bit i is the carry out of bit i (cin already folded in).
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         carry[i]   = gp_q[S][i].g;
         final_p[i] = gp_q[S][i].p;
      end
      unused_p = ^final_p;
   end

   // NOTE: pipeline data needs no reset; the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      if (adv) begin
         gp_q[0]  <= gp_in;
         p_q[0]   <= bus.a ^ bus.b;
         cin_q[0] <= bus.cin;
         for (int s = 1; s <= S; s++) begin
            gp_q[s]  <= lvl_out[last_lvl(s)];
            p_q[s]   <= p_q[s-1];
            cin_q[s] <= cin_q[s-1];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all stages shift off the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q         <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
      end else if (adv) begin
         v_q         <= {v_q[S-1:0], bus.in_valid};
         out_valid_q <= v_q[S];
         if (v_q[S]) begin
            sum_q  <= p_q[S] ^ {carry[WIDTH-2:0], cin_q[S]};
            cout_q <= carry[WIDTH-1];
         end
      end
   end

`ifdef KSA_PIPE_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (adv && v_q[S]) begin
         ovf_q <= carry[WIDTH-1] ^ carry[WIDTH-2];
      end
   end

   assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ksa_pipe.sv
// Scoreboard bench for ksa_pipe: 32-bit/1-level, 13-bit/2-level and exhaustive 8-bit instances.
module tb_ksa_pipe;

   localparam int LAT32 = 7;
   localparam int LAT13 = 4;
   localparam int LAT8  = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ksa_pipe_if #(.WIDTH(32)) bus32 ();
   ksa_pipe_if #(.WIDTH(13)) bus13 ();
   ksa_pipe_if #(.WIDTH(8))  bus8 ();

   ksa_pipe #(.WIDTH(32), .LVL_PER_STAGE(1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
   ksa_pipe #(.WIDTH(13), .LVL_PER_STAGE(2)) dut13 (.clk(clk), .rst_n(rst_n), .bus(bus13.slave));
   ksa_pipe #(.WIDTH(8),  .LVL_PER_STAGE(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

   int errors = 0;
   int checks = 0;

   logic [32:0] q32 [$];
   logic [14:0] q13 [$];
   logic [8:0]  q8  [$];

   // Drive one cycle on the 32-bit instance; report acceptance and any completed result.
   task automatic step32(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, input logic ordy,
                         output logic acc, output logic pop, output logic [32:0] got);
      @(negedge clk);
      bus32.in_valid = iv; bus32.a = ia; bus32.b = ib; bus32.cin = ic; bus32.out_ready = ordy;
      #1;
      pop = bus32.out_valid && bus32.out_ready;
      got = {bus32.cout, bus32.sum};
      acc = iv && bus32.in_ready;
      if (acc) q32.push_back({1'b0, ia} + {1'b0, ib} + 33'(ic));
   endtask

   task automatic step13(input logic iv, input logic [12:0] ia, input logic [12:0] ib,
                         input logic ic, output logic pop, output logic [14:0] got);
      logic [13:0] s;
      logic        v;
      @(negedge clk);
      bus13.in_valid = iv; bus13.a = ia; bus13.b = ib; bus13.cin = ic; bus13.out_ready = 1'b1;
      #1;
      pop = bus13.out_valid;
`ifdef KSA_PIPE_OVF_EN
      got = {bus13.ovf, bus13.cout, bus13.sum};
`else
      got = {1'b0, bus13.cout, bus13.sum};
`endif
      if (iv && bus13.in_ready) begin
         s = {1'b0, ia} + {1'b0, ib} + 14'(ic);
`ifdef KSA_PIPE_OVF_EN
         v = (ia[12] == ib[12]) && (s[12] != ia[12]);
`else
         v = 1'b0;
`endif
         q13.push_back({v, s});
      end
   endtask

   task automatic step8(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, output logic pop, output logic [8:0] got);
      @(negedge clk);
      bus8.in_valid = iv; bus8.a = ia; bus8.b = ib; bus8.cin = ic; bus8.out_ready = 1'b1;
      #1;
      pop = bus8.out_valid;
      got = {bus8.cout, bus8.sum};
      if (iv && bus8.in_ready) q8.push_back({1'b0, ia} + {1'b0, ib} + 9'(ic));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({bus32.out_valid, bus32.cout, bus32.sum} !== 34'h0) begin
         errors++;
         $display("FAIL reset_outputs got valid=%b cout=%b sum=%h want 0/0/0",
                  bus32.out_valid, bus32.cout, bus32.sum);
      end
      checks++;
      if ({bus13.out_valid, bus8.out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL reset_valid_small got %b%b want 00", bus13.out_valid, bus8.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus32.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", bus32.in_ready);
      end
   endtask

   task automatic test_latency();
      logic acc, pop, found;
      logic [32:0] got, exp;
      int lat;
      found = 1'b0;
      lat = -1;
      step32(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, acc, pop, got);
      for (int n = 1; n <= 20; n++) begin
         step32(1'b0, '0, '0, 1'b0, 1'b1, acc, pop, got);
         if (pop) begin
            if (!found) lat = n;
            found = 1'b1;
            exp = (q32.size() != 0) ? q32.pop_front() : 33'bx;
            checks++;
            if (got !== exp || got !== 33'h2) begin
               errors++;
               $display("FAIL latency_value got %h want %h", got, exp);
            end
         end
      end
      checks++;
      if (lat != LAT32) begin
         errors++;
         $display("FAIL latency_cycles got %0d want %0d", lat, LAT32);
      end
   endtask

   task automatic test_wrap();
      logic acc, pop;
      logic [32:0] got, exp;
      logic [31:0] va [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
      logic [31:0] vb [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
      logic        vc [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [32:0] ve [4] = '{33'h1_FFFF_FFFF, 33'h1_0000_0000, 33'h1_0000_0000, 33'h0_0000_0000};
      int got_n;
      got_n = 0;
      for (int i = 0; i < 4 + LAT32 + 4; i++) begin
         if (i < 4) step32(1'b1, va[i], vb[i], vc[i], 1'b1, acc, pop, got);
         else       step32(1'b0, '0, '0, 1'b0, 1'b1, acc, pop, got);
         if (pop) begin
            exp = (q32.size() != 0) ? q32.pop_front() : 33'bx;
            checks++;
            if (got !== exp || (got_n < 4 && got !== ve[got_n])) begin
               errors++;
               $display("FAIL wrap_%0d got %h want %h", got_n, got, exp);
            end
            got_n++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic acc, pop;
      logic [32:0] got, exp;
      logic [31:0] ra, rb;
      logic rc;
      int sent, rcvd, first, last;
      sent = 0; rcvd = 0; first = -1; last = -1;
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      for (int cyc = 0; cyc < 100 + LAT32 + 10; cyc++) begin
         step32(sent < 100, ra, rb, rc, 1'b1, acc, pop, got);
         if (acc) begin
            sent++;
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
         end
         if (pop) begin
            exp = (q32.size() != 0) ? q32.pop_front() : 33'bx;
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL b2b_beat_%0d got %h want %h", rcvd, got, exp);
            end
            if (first < 0) first = cyc;
            last = cyc;
            rcvd++;
         end
      end
      checks++;
      if (rcvd != 100 || last - first != 99) begin
         errors++;
         $display("FAIL b2b_throughput got %0d results over %0d cycles want 100 over 100",
                  rcvd, last - first + 1);
      end
   endtask

   task automatic test_stall();
      logic acc, pop, ordy;
      logic [32:0] got, exp, held;
      logic [31:0] ra, rb;
      logic rc;
      int sent, rcvd;
      sent = 0; rcvd = 0; held = '0;
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      for (int cyc = 0; cyc < 200 && rcvd < 30; cyc++) begin
         ordy = !(cyc >= 12 && cyc < 22);
         step32(sent < 30, ra, rb, rc, ordy, acc, pop, got);
         if (acc) begin
            sent++;
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
         end
         if (cyc == 12) held = got;
         if (cyc > 12 && cyc < 22) begin
            checks++;
            if (got !== held || bus32.out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold cyc %0d got %h valid %b want %h valid 1",
                        cyc, got, bus32.out_valid, held);
            end
         end
         if (cyc == 21) begin
            checks++;
            if (bus32.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_in_ready got %b want 0", bus32.in_ready);
            end
         end
         if (pop) begin
            exp = (q32.size() != 0) ? q32.pop_front() : 33'bx;
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL stall_beat_%0d got %h want %h", rcvd, got, exp);
            end
            rcvd++;
         end
      end
      checks++;
      if (rcvd != 30 || q32.size() != 0) begin
         errors++;
         $display("FAIL stall_count got %0d results (%0d pending) want 30 (0 pending)",
                  rcvd, q32.size());
      end
   endtask

   task automatic test_reset_midflight();
      logic acc, pop, found;
      logic [32:0] got, exp;
      int stale, lat;
      stale = 0; found = 1'b0; lat = -1;
      for (int i = 0; i < 4; i++) step32(1'b1, $urandom, $urandom, 1'b1, 1'b1, acc, pop, got);
      @(negedge clk);
      bus32.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      q32.delete();
      for (int i = 0; i < 12; i++) begin
         step32(1'b0, '0, '0, 1'b0, 1'b1, acc, pop, got);
         if (bus32.out_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0) begin
         errors++;
         $display("FAIL midreset_stale got %0d valid cycles want 0", stale);
      end
      step32(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1, acc, pop, got);
      for (int n = 1; n <= 20; n++) begin
         step32(1'b0, '0, '0, 1'b0, 1'b1, acc, pop, got);
         if (pop) begin
            if (!found) lat = n;
            found = 1'b1;
            exp = (q32.size() != 0) ? q32.pop_front() : 33'bx;
            checks++;
            if (got !== exp || got !== 33'h0_2222_2222) begin
               errors++;
               $display("FAIL midreset_value got %h want %h", got, exp);
            end
         end
      end
      checks++;
      if (lat != LAT32) begin
         errors++;
         $display("FAIL midreset_latency got %0d want %0d", lat, LAT32);
      end
   endtask

   task automatic test_ovf13();
      logic pop, found;
      logic [14:0] got, exp;
      int lat, rcvd;
      found = 1'b0; lat = -1; rcvd = 0;
      step13(1'b1, 13'h0FFF, 13'h0001, 1'b0, pop, got);
      for (int n = 1; n <= 40; n++) begin
         if (n <= 20) step13(1'b1, 13'($urandom), 13'($urandom), 1'($urandom), pop, got);
         else         step13(1'b0, '0, '0, 1'b0, pop, got);
         if (pop) begin
            if (!found) begin
               lat = n;
               checks++;
`ifdef KSA_PIPE_OVF_EN
               if (got !== 15'h5000) begin
`else
               if (got !== 15'h1000) begin
`endif
                  errors++;
                  $display("FAIL w13_directed got %h want sum=1000 cout=0 ovf=1", got);
               end
            end
            found = 1'b1;
            exp = (q13.size() != 0) ? q13.pop_front() : 15'bx;
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL w13_beat_%0d got %h want %h", rcvd, got, exp);
            end
            rcvd++;
         end
      end
      checks++;
      if (lat != LAT13 || rcvd != 21) begin
         errors++;
         $display("FAIL w13_latency got lat=%0d n=%0d want lat=%0d n=21", lat, rcvd, LAT13);
      end
   endtask

   task automatic test_sweep8();
      logic pop;
      logic [8:0] got, exp;
      logic [7:0] va, vb;
      int rcvd, idx;
      rcvd = 0; idx = 0;
      for (int cyc = 0; cyc < 65536 + LAT8 + 8; cyc++) begin
         va = 8'(idx >> 8);
         vb = 8'(idx);
         step8(idx < 65536, va, vb, va[0] ^ vb[7], pop, got);
         if (idx < 65536) idx++;
         if (pop) begin
            exp = (q8.size() != 0) ? q8.pop_front() : 9'bx;
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL w8_sweep_%0d got %h want %h", rcvd, got, exp);
            end
            rcvd++;
         end
      end
      checks++;
      if (rcvd != 65536) begin
         errors++;
         $display("FAIL w8_count got %0d want 65536", rcvd);
      end
   endtask

   initial begin
      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b1;
      bus13.in_valid = 1'b0; bus13.a = '0; bus13.b = '0; bus13.cin = 1'b0; bus13.out_ready = 1'b1;
      bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b1;
      test_reset();
      test_latency();
      test_wrap();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      test_ovf13();
      test_sweep8();
      checks++;
      if (q32.size() + q13.size() + q8.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected got %0d want 0", q32.size() + q13.size() + q8.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
